// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX datapath between NUM_REQ byte producers.
// A grant is held until TX raises and drops busy, or until the busy-rise timeout abandons the frame.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_busy,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_data_valid,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);

    localparam int SW    = IDX_W + 1;
    localparam int NSLOT = 2**IDX_W;
    localparam int CW    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_RISE,
        WAIT_FALL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic [CW-1:0]    cnt;
    logic [NSLOT-1:0] valid_ext;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             capture;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             timeout_set;

    // Index base+off reduced modulo NUM_REQ; off never exceeds NUM_REQ so one subtraction suffices.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        logic [SW-1:0] sum;
        sum = SW'(base) + SW'(off);
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        return sum[IDX_W-1:0];
    endfunction

    assign valid_ext = NSLOT'(req_valid);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!win_found && valid_ext[rr_index(ptr, off)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(ptr, off);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && !tx_busy) begin
                    capture    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_clr    = 1'b1;
                state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (tx_busy) begin
                    state_next = WAIT_FALL;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    // TX never picked the byte up: drop it and flag the loss.
                    timeout_set = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_p_data   <= '0;
            grant_id    <= '0;
            ptr         <= IDX_W'(NUM_REQ - 1);
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (capture) begin
                tx_p_data <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                grant_id  <= win_idx;
                ptr       <= win_idx;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign tx_data_valid = (state == LOAD);
    assign arb_busy      = (state != IDLE);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == LOAD) && (grant_id == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner-case sequences and a
// randomized run checked against a timeline model of round-robin frames.
module tb_uart_tx_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int BT = 16;
    localparam logic [31:0] TABLE_DATA = 32'h1312_1110;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           tx_busy;
    logic [DW-1:0]  tx_p_data;
    logic           tx_data_valid;
    logic [IW-1:0]  grant_id;
    logic           arb_busy;
    logic           timeout_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] valid;
        logic [1:0] grant;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .IDX_W       (IW),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_busy      (tx_busy),
        .tx_p_data    (tx_p_data),
        .tx_data_valid(tx_data_valid),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy),
        .timeout_err  (timeout_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        req_valid = valid;
        req_data  = data;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Round-robin choice straight from the rule: first pending index after the last grant, wrapping.
    function automatic int rr_pick(input int last, input logic [3:0] pend);
        for (int k = 1; k <= NR; k++) begin
            if (pend[(last + k) % NR]) begin
                return (last + k) % NR;
            end
        end
        return 0;
    endfunction

    // Called at a negedge with the arbiter idle; TX raises busy `rise` cycles after the load pulse for `len` cycles.
    task automatic run_frame(input string name, input logic [3:0] valid, input logic [31:0] data,
                             input int rise, input int len, input logic [1:0] exp_grant, input logic [7:0] exp_data);
        int extra;
        applyStimulus(valid, data);
        @(negedge clk);
        checkOutput({name, " valid"}, 32'(tx_data_valid), 32'd1);
        checkOutput({name, " ready"}, 32'(req_ready), 32'(4'b0001 << exp_grant));
        checkOutput({name, " grant"}, 32'(grant_id), 32'(exp_grant));
        checkOutput({name, " data"}, 32'(tx_p_data), 32'(exp_data));
        req_valid = '0;
        extra = 0;
        for (int n = 1; n <= rise + len; n++) begin
            @(negedge clk);
            if (tx_data_valid || (req_ready != '0)) extra++;
            if (n == rise) begin
                checkOutput({name, " busy mid"}, 32'(arb_busy), 32'd1);
                tx_busy = 1'b1;
            end
            if (n == rise + len) tx_busy = 1'b0;
        end
        @(negedge clk);
        checkOutput({name, " idle after"}, 32'(arb_busy), 32'd0);
        checkOutput({name, " extra pulses"}, 32'(extra), 32'd0);
    endtask

    task automatic reset_in_wait_fall(input string name);
        applyStimulus(4'b0100, TABLE_DATA);
        @(negedge clk);
        checkOutput({name, " load grant"}, 32'(grant_id), 32'd2);
        req_valid = '0;
        @(negedge clk);
        tx_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput({name, " in frame"}, 32'(arb_busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput({name, " rst data"}, 32'(tx_p_data), 32'd0);
        checkOutput({name, " rst valid"}, 32'(tx_data_valid), 32'd0);
        checkOutput({name, " rst ready"}, 32'(req_ready), 32'd0);
        checkOutput({name, " rst grant"}, 32'(grant_id), 32'd0);
        checkOutput({name, " rst arb_busy"}, 32'(arb_busy), 32'd0);
        checkOutput({name, " rst timeout"}, 32'(timeout_err), 32'd0);
        @(negedge clk);
        tx_busy = 1'b0;
        rst     = 1'b1;
    endtask

    // Timeline model: each frame frees the arbiter at a cycle computed from the TX behaviour chosen for it.
    task automatic random_test(input int ncyc);
        logic [3:0] rv;
        logic [7:0] rd [NR];
        logic [7:0] exp_d;
        int ptr_m, last_g, idle_from, load_cyc, rise, len, terr_at, exp_g;
        bit pending, frame_to, have_frame, terr;
        rv = '0;
        for (int i = 0; i < NR; i++) rd[i] = '0;
        exp_d = '0;
        ptr_m = NR - 1; last_g = 0; idle_from = 0; load_cyc = 0; rise = 0; len = 0;
        terr_at = 0; exp_g = 0; pending = 0; frame_to = 0; have_frame = 0; terr = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (pending && cyc == load_cyc) begin
                checkOutput("rnd load valid", 32'(tx_data_valid), 32'd1);
                checkOutput("rnd load ready", 32'(req_ready), 32'(1 << exp_g));
                checkOutput("rnd load data", 32'(tx_p_data), 32'(exp_d));
                checkOutput("rnd load busy", 32'(arb_busy), 32'd1);
                pending    = 0;
                have_frame = 1;
                last_g     = exp_g;
                rv[exp_g]  = 1'b0;
                rise       = int'($urandom_range(1, BT + 4));
                len        = int'($urandom_range(1, 6));
                frame_to   = (rise > BT);
                if (frame_to) begin
                    idle_from = cyc + BT + 1;
                    if (!terr) begin
                        terr    = 1;
                        terr_at = idle_from;
                    end
                end else begin
                    idle_from = cyc + rise + len + 1;
                end
            end else begin
                checkOutput("rnd no valid", 32'(tx_data_valid), 32'd0);
                checkOutput("rnd no ready", 32'(req_ready), 32'd0);
                checkOutput("rnd arb_busy", 32'(arb_busy), 32'(cyc < idle_from));
            end
            checkOutput("rnd grant_id", 32'(grant_id), 32'(last_g));
            checkOutput("rnd timeout_err", 32'(timeout_err), 32'(terr && cyc >= terr_at));
            tx_busy = have_frame && !frame_to && (cyc >= load_cyc + rise) && (cyc < load_cyc + rise + len);
            for (int i = 0; i < NR; i++) begin
                if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1;
                    rd[i] = 8'($urandom);
                end
            end
            applyStimulus(rv, {rd[3], rd[2], rd[1], rd[0]});
            if (!pending && cyc >= idle_from && rv != '0 && !tx_busy) begin
                exp_g    = rr_pick(ptr_m, rv);
                ptr_m    = exp_g;
                exp_d    = rd[exp_g];
                pending  = 1;
                load_cyc = cyc + 1;
            end
        end
        req_valid = '0;
        tx_busy   = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'b1111, 2'd0, 8'h10};
        vecs[1]  = '{4'b1111, 2'd1, 8'h11};
        vecs[2]  = '{4'b1111, 2'd2, 8'h12};
        vecs[3]  = '{4'b1111, 2'd3, 8'h13};
        vecs[4]  = '{4'b1111, 2'd0, 8'h10};
        vecs[5]  = '{4'b0100, 2'd2, 8'h12};
        vecs[6]  = '{4'b1001, 2'd3, 8'h13};
        vecs[7]  = '{4'b1001, 2'd0, 8'h10};
        vecs[8]  = '{4'b0010, 2'd1, 8'h11};
        vecs[9]  = '{4'b1001, 2'd3, 8'h13};
        vecs[10] = '{4'b1001, 2'd0, 8'h10};
        vecs[11] = '{4'b0001, 2'd0, 8'h10};
        vecs[12] = '{4'b1000, 2'd3, 8'h13};
        vecs[13] = '{4'b0110, 2'd1, 8'h11};

        rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset tx_p_data", 32'(tx_p_data), 32'd0);
        checkOutput("reset tx_data_valid", 32'(tx_data_valid), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset arb_busy", 32'(arb_busy), 32'd0);
        checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;

        $display("[TB] single requester 2");
        run_frame("single", 4'b0100, 32'h00A5_0000, 2, 20, 2'd2, 8'hA5);

        $display("[TB] vector table");
        do_reset();
        for (int i = 0; i < 14; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].valid, TABLE_DATA, 2, 3, vecs[i].grant, vecs[i].data);
        end

        $display("[TB] busy timeout");
        do_reset();
        applyStimulus(4'b0001, TABLE_DATA);
        @(negedge clk);
        checkOutput("to load", 32'(tx_data_valid), 32'd1);
        checkOutput("to err before", 32'(timeout_err), 32'd0);
        req_valid = '0;
        n = 0;
        while (arb_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to cycles to idle", 32'(n), 32'(BT + 1));
        checkOutput("to err set", 32'(timeout_err), 32'd1);
        run_frame("to next", 4'b0010, TABLE_DATA, 3, 4, 2'd1, 8'h11);
        checkOutput("to err sticky", 32'(timeout_err), 32'd1);

        $display("[TB] reset during frame");
        reset_in_wait_fall("rst1");
        run_frame("rst1 first", 4'b0010, TABLE_DATA, 2, 2, 2'd1, 8'h11);
        reset_in_wait_fall("rst2");
        run_frame("rst2 first", 4'b0011, TABLE_DATA, 2, 2, 2'd0, 8'h10);

        $display("[TB] busy held in idle");
        do_reset();
        tx_busy = 1'b1;
        applyStimulus(4'b0001, TABLE_DATA);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("hold valid", 32'(tx_data_valid), 32'd0);
            checkOutput("hold arb_busy", 32'(arb_busy), 32'd0);
            checkOutput("hold data", 32'(tx_p_data), 32'd0);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        checkOutput("hold release valid", 32'(tx_data_valid), 32'd1);
        checkOutput("hold release grant", 32'(grant_id), 32'd0);
        checkOutput("hold release data", 32'(tx_p_data), 32'h10);
        req_valid = '0;
        @(negedge clk);
        tx_busy = 1'b1;
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        checkOutput("hold frame done", 32'(arb_busy), 32'd0);

        $display("[TB] randomized run");
        do_reset();
        random_test(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART TX datapath between NUM_REQ byte producers, e.g. a register-readback path, a status reporter and a loopback echo.
- Picks one pending requester by round-robin and captures its byte.
- Hands the byte to TX as a one-cycle valid pulse.
- Holds off further grants until TX has raised and then dropped busy.
- Sits between the producer blocks and the UART TX top.

Parameters:
DATA_WIDTH, 8, width of one UART payload byte.
NUM_REQ, 4, number of requesters; legal range 2..8.
IDX_W, 2, width of grant_id; must satisfy 2**IDX_W >= NUM_REQ.
BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after handoff before the frame is abandoned.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  bit i high = requester i holds a byte; must stay high with stable data until req_ready[i].
req_data  in  NUM_REQ*DATA_WIDTH  byte of requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  out  NUM_REQ  one-cycle pulse, one-hot: byte of requester i accepted.
tx_busy  in  1  TX datapath busy, high for the duration of a frame.
tx_p_data  out  DATA_WIDTH  registered byte to TX.
tx_data_valid  out  1  one-cycle load strobe to TX.
grant_id  out  IDX_W  index of the current/last granted requester.
arb_busy  out  1  high in every state except IDLE.
timeout_err  out  1  sticky; set on BUSY_TIMEOUT expiry, cleared only by reset.

Behaviour:
Reset (async, any state, including mid-frame):
- state IDLE; tx_p_data=0, tx_data_valid=0, req_ready=0, grant_id=0, arb_busy=0, timeout_err=0.
- last-grant pointer = NUM_REQ-1, so requester 0 has priority first.
- timeout counter = 0.

States: IDLE, LOAD, WAIT_RISE, WAIT_FALL.

IDLE:
- No requester valid, or tx_busy high: stay in IDLE; nothing is captured.
- Any req_valid high and tx_busy low:
  - Winner = first set bit searching upward from pointer+1, wrapping at NUM_REQ-1 back to 0.
  - Capture that requester's byte into tx_p_data and its index into grant_id.
  - Update pointer to the winner; go to LOAD.

LOAD (exactly 1 cycle):
- tx_data_valid=1 and req_ready[grant_id]=1; clear the timeout counter; go to WAIT_RISE.
- Latency: req_valid sampled in IDLE → tx_data_valid and req_ready one cycle later.

WAIT_RISE:
- tx_busy=1: go to WAIT_FALL.
- Otherwise increment the counter.
- Counter reaching BUSY_TIMEOUT-1 with tx_busy still low: set timeout_err and return to IDLE. The byte is dropped, not retried.

WAIT_FALL:
- Stay while tx_busy=1; on tx_busy=0 go to IDLE.
- Back-to-back frames: next grant is decided in the IDLE cycle, so the minimum gap between tx_data_valid pulses is 1 (LOAD) + WAIT_RISE + WAIT_FALL + 1 (IDLE) cycles.

Other rules:
- req_valid changes outside IDLE are ignored until the next IDLE cycle.
- A requester dropping valid before capture is simply not selected.
- A new request and TX completion in the same cycle: the completion moves WAIT_FALL→IDLE, and arbitration happens in the following cycle.
- At most one req_ready bit set in any cycle; req_ready never high outside LOAD.
- Pointer arithmetic is modulo NUM_REQ; indices NUM_REQ..2**IDX_W-1 are never produced.

Test Plan:
1. Only req_valid[2], data 0xA5; TX model raises busy 2 cycles after load and holds it 20 cycles → tx_p_data=0xA5, one tx_data_valid pulse, req_ready=4'b0100 in the same cycle, grant_id=2, arb_busy low after busy falls.
2. All four requesters valid continuously with data 0x10..0x13 → grant order 0,1,2,3,0; tx bytes 0x10,0x11,0x12,0x13,0x10; exactly one tx_data_valid per frame.
3. Grant requester 1, then requesters 0 and 3 both valid → next grant is 3, then 0 (wrap from pointer).
4. tx_busy never rises after LOAD → IDLE after exactly BUSY_TIMEOUT cycles in WAIT_RISE, timeout_err=1 and stays 1. The next request is still served normally.
5. rst asserted while in WAIT_FALL with tx_busy high → all outputs 0 immediately. After release, request 1 alone with tx_busy low is granted first. Also repeat with requesters 0 and 1 both valid → requester 0 granted first.
6. tx_busy high in IDLE with req_valid[0]=1 → no capture and no pulse until tx_busy low; then grant within 1 cycle.
